// File: rtl/l1d_fifo_pkg.sv
// Shared sizing helpers for the L1D register FIFO and its storage.
package l1d_fifo_pkg;

    localparam int DEFAULT_DEPTH = 8;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH + 1);

endpackage

// File: rtl/l1d_reg_fifo_ram.sv
// Register-array dual-port RAM with a synchronous write and a combinational read.
module reg_dual_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign rd = re ? mem_q[ra] : '0;

endmodule

// File: rtl/l1d_reg_fifo.sv
// First-word-fall-through valid/ready FIFO for L1D request/response queues.
module l1d_reg_fifo
    import l1d_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [WIDTH-1:0]          enq_data,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [WIDTH-1:0]          deq_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      afull
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             enq_fire, deq_fire;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                       (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    assign count     = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign afull     = (count >= AFULL_C);

    // enq_ready depends only on full, so no combinational path from deq_ready.
    assign enq_ready = ~full;
    assign deq_valid = ~empty;

    assign enq_fire  = enq_valid & enq_ready & ~flush;
    assign deq_fire  = deq_valid & deq_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload is never reset; only the pointers define what is visible.
    reg_dual_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_ram (
        .clk (clk),
        .rst (1'b0),
        .we  (enq_fire),
        .wa  (wr_ptr_q[IDX_W-1:0]),
        .wd  (enq_data),
        .re  (1'b1),
        .ra  (rd_ptr_q[IDX_W-1:0]),
        .rd  (deq_data)
    );

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq_fire && full)) else $error("enqueue fired while full");

    a_no_deq_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(deq_fire && empty)) else $error("dequeue fired while empty");

endmodule
